// File: rtl/switch_mcu_pkg.sv
// Shared RV32I encoding constants: op indices, major opcodes, format classes and fixed words.
// Used by both the MCU instruction decoder and switch_mcu_encoder.
package switch_mcu_pkg;

    localparam logic [5:0] OP_LUI    = 6'd0,  OP_AUIPC  = 6'd1,  OP_JAL    = 6'd2,  OP_JALR   = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4,  OP_BNE    = 6'd5,  OP_BLT    = 6'd6,  OP_BGE    = 6'd7;
    localparam logic [5:0] OP_BLTU   = 6'd8,  OP_BGEU   = 6'd9;
    localparam logic [5:0] OP_LB     = 6'd10, OP_LH     = 6'd11, OP_LW     = 6'd12, OP_LBU    = 6'd13;
    localparam logic [5:0] OP_LHU    = 6'd14, OP_SB     = 6'd15, OP_SH     = 6'd16, OP_SW     = 6'd17;
    localparam logic [5:0] OP_ADDI   = 6'd18, OP_SLTI   = 6'd19, OP_SLTIU  = 6'd20, OP_XORI   = 6'd21;
    localparam logic [5:0] OP_ORI    = 6'd22, OP_ANDI   = 6'd23, OP_SLLI   = 6'd24, OP_SRLI   = 6'd25;
    localparam logic [5:0] OP_SRAI   = 6'd26, OP_ADD    = 6'd27, OP_SUB    = 6'd28, OP_SLL    = 6'd29;
    localparam logic [5:0] OP_SLT    = 6'd30, OP_SLTU   = 6'd31, OP_XOR    = 6'd32, OP_SRL    = 6'd33;
    localparam logic [5:0] OP_SRA    = 6'd34, OP_OR     = 6'd35, OP_AND    = 6'd36, OP_FENCE  = 6'd37;
    localparam logic [5:0] OP_FENCE_I = 6'd38, OP_ECALL = 6'd39, OP_EBREAK = 6'd40, OP_CSRRW  = 6'd41;
    localparam logic [5:0] OP_CSRRS  = 6'd42, OP_CSRRC  = 6'd43, OP_CSRRWI = 6'd44, OP_CSRRSI = 6'd45;
    localparam logic [5:0] OP_CSRRCI = 6'd46;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] WORD_NOP     = 32'h0000_0013;
    localparam logic [31:0] WORD_FENCE_I = 32'h0000_100F;
    localparam logic [31:0] WORD_ECALL   = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK  = 32'h0010_0073;

    // FMT_SYS means "the immediate already holds the complete word".
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       legal;
    } op_ctl_t;

    function automatic op_ctl_t mk_ctl(input fmt_e fmt, input logic [6:0] opc,
                                       input logic [2:0] f3, input logic [6:0] f7);
        op_ctl_t c;
        c.fmt    = fmt;
        c.opcode = opc;
        c.funct3 = f3;
        c.funct7 = f7;
        c.legal  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/switch_mcu_enc_pack.sv
// Combinational field packer: places opcode, functs, registers and immediate bits per format.
module switch_mcu_enc_pack
    import switch_mcu_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = imm_i;
        case (fmt_i)
            FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: word_o = imm_i;
        endcase
    end

endmodule

// File: rtl/switch_mcu_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready on both sides.
// Optional immediate range checking is enabled by defining SWITCH_MCU_ENC_RANGE_CHECK_EN.
module switch_mcu_encoder
    import switch_mcu_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = WORD_NOP
) (
    input  logic             input_clk,
    input  logic             input_rst,
    input  logic             input_req_valid,
    output logic             output_req_ready,
    input  logic [5:0]       input_op,
    input  logic [4:0]       input_rd,
    input  logic [4:0]       input_rs1,
    input  logic [4:0]       input_rs2,
    input  logic [31:0]      input_imm,
    output logic [31:0]      output_inst,
    output logic             output_inst_valid,
    input  logic             input_inst_ready,
    output logic             output_illegal,
    output logic [CNT_W-1:0] output_inst_count
);

    function automatic op_ctl_t op_lookup(input logic [5:0] op);
        op_ctl_t c;
        c = mk_ctl(FMT_SYS, OPC_SYSTEM, 3'b000, F7_ZERO);
        c.legal = 1'b0;
        case (op)
            OP_LUI:    c = mk_ctl(FMT_U, OPC_LUI,      3'b000, F7_ZERO);
            OP_AUIPC:  c = mk_ctl(FMT_U, OPC_AUIPC,    3'b000, F7_ZERO);
            OP_JAL:    c = mk_ctl(FMT_J, OPC_JAL,      3'b000, F7_ZERO);
            OP_JALR:   c = mk_ctl(FMT_I, OPC_JALR,     3'b000, F7_ZERO);
            OP_BEQ:    c = mk_ctl(FMT_B, OPC_BRANCH,   3'b000, F7_ZERO);
            OP_BNE:    c = mk_ctl(FMT_B, OPC_BRANCH,   3'b001, F7_ZERO);
            OP_BLT:    c = mk_ctl(FMT_B, OPC_BRANCH,   3'b100, F7_ZERO);
            OP_BGE:    c = mk_ctl(FMT_B, OPC_BRANCH,   3'b101, F7_ZERO);
            OP_BLTU:   c = mk_ctl(FMT_B, OPC_BRANCH,   3'b110, F7_ZERO);
            OP_BGEU:   c = mk_ctl(FMT_B, OPC_BRANCH,   3'b111, F7_ZERO);
            OP_LB:     c = mk_ctl(FMT_I, OPC_LOAD,     3'b000, F7_ZERO);
            OP_LH:     c = mk_ctl(FMT_I, OPC_LOAD,     3'b001, F7_ZERO);
            OP_LW:     c = mk_ctl(FMT_I, OPC_LOAD,     3'b010, F7_ZERO);
            OP_LBU:    c = mk_ctl(FMT_I, OPC_LOAD,     3'b100, F7_ZERO);
            OP_LHU:    c = mk_ctl(FMT_I, OPC_LOAD,     3'b101, F7_ZERO);
            OP_SB:     c = mk_ctl(FMT_S, OPC_STORE,    3'b000, F7_ZERO);
            OP_SH:     c = mk_ctl(FMT_S, OPC_STORE,    3'b001, F7_ZERO);
            OP_SW:     c = mk_ctl(FMT_S, OPC_STORE,    3'b010, F7_ZERO);
            OP_ADDI:   c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b000, F7_ZERO);
            OP_SLTI:   c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b010, F7_ZERO);
            OP_SLTIU:  c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b011, F7_ZERO);
            OP_XORI:   c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b100, F7_ZERO);
            OP_ORI:    c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b110, F7_ZERO);
            OP_ANDI:   c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b111, F7_ZERO);
            OP_SLLI:   c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b001, F7_ZERO);
            OP_SRLI:   c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b101, F7_ZERO);
            OP_SRAI:   c = mk_ctl(FMT_I, OPC_OP_IMM,   3'b101, F7_ALT);
            OP_ADD:    c = mk_ctl(FMT_R, OPC_OP,       3'b000, F7_ZERO);
            OP_SUB:    c = mk_ctl(FMT_R, OPC_OP,       3'b000, F7_ALT);
            OP_SLL:    c = mk_ctl(FMT_R, OPC_OP,       3'b001, F7_ZERO);
            OP_SLT:    c = mk_ctl(FMT_R, OPC_OP,       3'b010, F7_ZERO);
            OP_SLTU:   c = mk_ctl(FMT_R, OPC_OP,       3'b011, F7_ZERO);
            OP_XOR:    c = mk_ctl(FMT_R, OPC_OP,       3'b100, F7_ZERO);
            OP_SRL:    c = mk_ctl(FMT_R, OPC_OP,       3'b101, F7_ZERO);
            OP_SRA:    c = mk_ctl(FMT_R, OPC_OP,       3'b101, F7_ALT);
            OP_OR:     c = mk_ctl(FMT_R, OPC_OP,       3'b110, F7_ZERO);
            OP_AND:    c = mk_ctl(FMT_R, OPC_OP,       3'b111, F7_ZERO);
            OP_FENCE:  c = mk_ctl(FMT_I, OPC_MISC_MEM, 3'b000, F7_ZERO);
            OP_FENCE_I, OP_ECALL, OP_EBREAK:
                       c = mk_ctl(FMT_SYS, OPC_SYSTEM, 3'b000, F7_ZERO);
            OP_CSRRW:  c = mk_ctl(FMT_I, OPC_SYSTEM,   3'b001, F7_ZERO);
            OP_CSRRS:  c = mk_ctl(FMT_I, OPC_SYSTEM,   3'b010, F7_ZERO);
            OP_CSRRC:  c = mk_ctl(FMT_I, OPC_SYSTEM,   3'b011, F7_ZERO);
            OP_CSRRWI: c = mk_ctl(FMT_I, OPC_SYSTEM,   3'b101, F7_ZERO);
            OP_CSRRSI: c = mk_ctl(FMT_I, OPC_SYSTEM,   3'b110, F7_ZERO);
            OP_CSRRCI: c = mk_ctl(FMT_I, OPC_SYSTEM,   3'b111, F7_ZERO);
            default:   c.legal = 1'b0;
        endcase
        return c;
    endfunction

`ifdef SWITCH_MCU_ENC_RANGE_CHECK_EN
    // True when v is the sign extension of its bits [msb:0].
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic signed [31:0] s;
        s = $signed(v) >>> msb;
        return (s == '0) || (s == '1);
    endfunction
`endif

    logic s2_adv, req_fire, out_fire;

    logic vld_p1_q, ill_p1_q;
    fmt_e fmt_p1_q;
    logic [6:0]  opc_p1_q, f7_p1_q;
    logic [2:0]  f3_p1_q;
    logic [4:0]  rd_p1_q, rs1_p1_q, rs2_p1_q;
    logic [31:0] imm_p1_q;

    logic vld_p2_q, ill_p2_q;
    logic [31:0] inst_p2_q;
    logic [CNT_W-1:0] cnt_q;

    op_ctl_t     ctl;
    logic        is_shift, is_fence, ill_d;
    fmt_e        fmt_d;
    logic [4:0]  rd_d, rs1_d;
    logic [31:0] imm_d, pack_word;

    assign s2_adv           = !vld_p2_q || input_inst_ready;
    assign output_req_ready = !vld_p1_q || s2_adv;
    assign req_fire         = input_req_valid && output_req_ready;
    assign out_fire         = vld_p2_q && input_inst_ready;

    // S1 next state: look up encoding, normalise fields, fold fixed words and rejects into FMT_SYS.
    always_comb begin
        ctl      = op_lookup(input_op);
        is_shift = (input_op >= OP_SLLI) && (input_op <= OP_SRAI);
        is_fence = (input_op == OP_FENCE);
        fmt_d    = ctl.fmt;
        ill_d    = !ctl.legal;
        rd_d     = input_rd;
        rs1_d    = input_rs1;
        imm_d    = input_imm;
        if (is_shift) begin
            imm_d = {20'b0, ctl.funct7, input_imm[4:0]};
        end
        if (is_fence) begin
            imm_d = {24'b0, input_imm[7:0]};
            rd_d  = 5'd0;
            rs1_d = 5'd0;
        end
        case (input_op)
            OP_FENCE_I: imm_d = WORD_FENCE_I;
            OP_ECALL:   imm_d = WORD_ECALL;
            OP_EBREAK:  imm_d = WORD_EBREAK;
            default:    ;
        endcase
`ifdef SWITCH_MCU_ENC_RANGE_CHECK_EN
        begin
            logic rng_ok;
            logic is_csr;
            is_csr = (input_op >= OP_CSRRW) && (input_op <= OP_CSRRCI);
            rng_ok = 1'b1;
            if (is_shift)      rng_ok = (input_imm[31:5] == '0);
            else if (is_fence) rng_ok = (input_imm[31:8] == '0);
            // CSR numbers are unsigned 12-bit addresses, not sign-extended offsets.
            else if (is_csr)   rng_ok = (input_imm[31:12] == '0);
            else begin
                case (ctl.fmt)
                    FMT_I, FMT_S: rng_ok = fits_signed(input_imm, 11);
                    FMT_B:        rng_ok = fits_signed(input_imm, 12) && !input_imm[0];
                    FMT_J:        rng_ok = fits_signed(input_imm, 20) && !input_imm[0];
                    FMT_U:        rng_ok = (input_imm[11:0] == '0);
                    default:      rng_ok = 1'b1;
                endcase
            end
            ill_d = ill_d || !rng_ok;
        end
`endif
        if (ill_d) begin
            fmt_d = FMT_SYS;
            imm_d = NOP_WORD;
        end
    end

    always_ff @(posedge input_clk) begin
        if (req_fire) begin
            ill_p1_q <= ill_d;
            fmt_p1_q <= fmt_d;
            opc_p1_q <= ctl.opcode;
            f3_p1_q  <= ctl.funct3;
            f7_p1_q  <= ctl.funct7;
            rd_p1_q  <= rd_d;
            rs1_p1_q <= rs1_d;
            rs2_p1_q <= input_rs2;
            imm_p1_q <= imm_d;
        end
    end

    // S1 -> S2 boundary: pack the registered fields into the output word.
    switch_mcu_enc_pack u_pack (
        .fmt_i    (fmt_p1_q),
        .opcode_i (opc_p1_q),
        .funct3_i (f3_p1_q),
        .funct7_i (f7_p1_q),
        .rd_i     (rd_p1_q),
        .rs1_i    (rs1_p1_q),
        .rs2_i    (rs2_p1_q),
        .imm_i    (imm_p1_q),
        .word_o   (pack_word)
    );

    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            ill_p2_q  <= 1'b0;
            inst_p2_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (output_req_ready) vld_p1_q <= input_req_valid;
            if (s2_adv)           vld_p2_q <= vld_p1_q;
            if (s2_adv && vld_p1_q) begin
                inst_p2_q <= pack_word;
                ill_p2_q  <= ill_p1_q;
            end
            if (out_fire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign output_inst       = inst_p2_q;
    assign output_inst_valid = vld_p2_q;
    assign output_illegal    = ill_p2_q;
    assign output_inst_count = cnt_q;

endmodule

// File: tb/tb_switch_mcu_encoder.sv
// Directed bench for switch_mcu_encoder: table of single-request vectors plus stall and reset sequences.
module tb_switch_mcu_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        illegal;
    logic [15:0] inst_count;

    int n_cmp = 0;
    int n_err = 0;

    switch_mcu_encoder dut (
        .input_clk         (clk),
        .input_rst         (rst),
        .input_req_valid   (req_valid),
        .output_req_ready  (req_ready),
        .input_op          (op),
        .input_rd          (rd),
        .input_rs1         (rs1),
        .input_rs2         (rs2),
        .input_imm         (imm),
        .output_inst       (inst),
        .output_inst_valid (inst_valid),
        .input_inst_ready  (inst_ready),
        .output_illegal    (illegal),
        .output_inst_count (inst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_ill;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        req_valid = 1'b1;
    endtask

    task automatic apply_vec(input int i);
        logic early_valid;
        @(posedge clk); #1;
        drive(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
        @(posedge clk); #1;
        req_valid   = 1'b0;
        early_valid = inst_valid;
        @(posedge clk); #1;
        n_cmp++;
        if (early_valid !== 1'b0 || inst_valid !== 1'b1 || inst !== tbl[i].exp_inst ||
            illegal !== tbl[i].exp_ill) begin
            n_err++;
            $display("FAIL vec%0d op=%0d: got inst=%h ill=%b vld=%b early_vld=%b, expected inst=%h ill=%b vld=1 early_vld=0",
                     i, tbl[i].op, inst, illegal, inst_valid, early_valid, tbl[i].exp_inst, tbl[i].exp_ill);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{6'd18, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 32'h0050_0093, 1'b0};
        tbl[1]  = '{6'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        tbl[2]  = '{6'd26, 5'd3, 5'd3, 5'd0, 32'h0000_0004, 32'h4041_D193, 1'b0};
        tbl[3]  = '{6'd4,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
        tbl[4]  = '{6'd40, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 32'h0010_0073, 1'b0};
        tbl[5]  = '{6'd50, 5'd1, 5'd2, 5'd3, 32'h0000_0005, 32'h0000_0013, 1'b1};
        tbl[6]  = '{6'd39, 5'd4, 5'd4, 5'd4, 32'h0000_0000, 32'h0000_0073, 1'b0};
        tbl[7]  = '{6'd38, 5'd7, 5'd3, 5'd1, 32'h0000_0000, 32'h0000_100F, 1'b0};
        tbl[8]  = '{6'd27, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h0031_00B3, 1'b0};
        tbl[9]  = '{6'd28, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h4031_00B3, 1'b0};
        tbl[10] = '{6'd17, 5'd9, 5'd2, 5'd5, 32'h0000_0008, 32'h0051_2423, 1'b0};
        tbl[11] = '{6'd2,  5'd1, 5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0};
        tbl[12] = '{6'd41, 5'd1, 5'd2, 5'd0, 32'h0000_0300, 32'h3001_10F3, 1'b0};
        tbl[13] = '{6'd44, 5'd0, 5'd5, 5'd0, 32'h0000_0305, 32'h3052_D073, 1'b0};
        tbl[14] = '{6'd37, 5'd3, 5'd4, 5'd0, 32'h0000_00FF, 32'h0FF0_000F, 1'b0};
        tbl[15] = '{6'd63, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 32'h0000_0013, 1'b1};
        tbl[16] = '{6'd9,  5'd0, 5'd3, 5'd4, 32'h0000_0010, 32'h0041_F863, 1'b0};
        tbl[17] = '{6'd24, 5'd2, 5'd2, 5'd0, 32'h0000_001F, 32'h01F1_1113, 1'b0};
`ifdef SWITCH_MCU_ENC_RANGE_CHECK_EN
        tbl[18] = '{6'd18, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0000_0013, 1'b1};
        tbl[19] = '{6'd0,  5'd1, 5'd0, 5'd0, 32'h0000_1FFF, 32'h0000_0013, 1'b1};
`else
        tbl[18] = '{6'd18, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0093, 1'b0};
        tbl[19] = '{6'd0,  5'd1, 5'd0, 5'd0, 32'h0000_1FFF, 32'h0000_10B7, 1'b0};
`endif

        rst = 1'b1; req_valid = 1'b0; inst_ready = 1'b1;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_count", {16'b0, inst_count}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Stall: three back-to-back requests while the consumer holds off for three cycles.
        inst_ready = 1'b0;
        drive(6'd18, 5'd1, 5'd0, 5'd0, 32'd1);
        @(posedge clk); #1;
        chk("stall_ready_a", {31'b0, req_ready}, 32'd1);
        drive(6'd18, 5'd2, 5'd0, 5'd0, 32'd2);
        @(posedge clk); #1;
        drive(6'd18, 5'd3, 5'd0, 5'd0, 32'd3);
        chk("stall_ready_full", {31'b0, req_ready}, 32'd0);
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_word0", inst, 32'h0010_0093);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("stall_hold", inst, 32'h0010_0093);
            chk("stall_ready_low", {31'b0, req_ready}, 32'd0);
        end
        inst_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("order_word1", inst, 32'h0020_0113);
        @(posedge clk); #1;
        chk("order_word2", inst, 32'h0030_0193);
        @(posedge clk); #1;
        chk("drain_valid", {31'b0, inst_valid}, 32'd0);
        chk("stall_count", {16'b0, inst_count}, 32'd3);

        for (int i = 0; i < NV; i++) apply_vec(i);
        @(posedge clk); #1;
        chk("table_count", {16'b0, inst_count}, 32'(3 + NV));

        // Reset with two requests in flight.
        inst_ready = 1'b0;
        drive(6'd18, 5'd4, 5'd0, 5'd0, 32'd4);
        @(posedge clk); #1;
        drive(6'd18, 5'd5, 5'd0, 5'd0, 32'd5);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inst_ready = 1'b1;
        chk("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mid_rst_count", {16'b0, inst_count}, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("no_stale_word", {31'b0, inst_valid}, 32'd0);
        end
        chk("post_rst_count", {16'b0, inst_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
